// File: rtl/mem_if_pkg.sv
// Shared constants and types for SPRAM memory-interface initiators.
// Word size, read latency, address space and reset holdoff.
package mem_if_pkg;

  localparam int MEM_WORD_BYTES = 2;
  localparam int MEM_RD_LATENCY = 3;
  localparam int MEM_BYTES      = 131072;
  localparam int RESET_HOLDOFF  = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Head word is visible on rd_data whenever count is non-zero.
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage; cleared on reset so the head reads 0 when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Reads a run of 16-bit words from SPRAM and streams them out.
// Credit-limited issue keeps the return FIFO from overflowing.
module mem_stream_reader
  import mem_if_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] num_words,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [15:0] mem_data_write,
  input  logic [15:0] mem_data_read,
  input  logic        mem_data_read_valid,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t        state;
  logic [31:0]   addr_q;
  logic [15:0]   remaining;
  logic [1:0]    outstanding;
  logic [1:0]    holdoff;
  logic          rd_en_q;
  logic [CW-1:0] fifo_count;
  logic          credit_ok;
  logic          issue;
  logic          push;
  logic          pop;
  logic          drain_done;

  assign credit_ok = (32'(outstanding) + 32'(fifo_count))
                     < 32'(FIFO_DEPTH);
  assign issue = (state == ISSUE) && (remaining != '0)
                 && !rd_en_q && credit_ok;
  assign push  = mem_data_read_valid && (state != IDLE);
  assign pop   = out_valid && out_ready;

  assign drain_done = (state == DRAIN) && (outstanding == '0)
                      && !push
                      && ((fifo_count == '0)
                          || ((fifo_count == CW'(1)) && pop));

  assign mem_addr       = addr_q;
  assign mem_rd_en      = issue;
  assign mem_wr_en      = 1'b0;
  assign mem_data_write = '0;
  assign out_valid      = (fifo_count != '0);

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (mem_data_read),
    .pop     (pop),
    .rd_data (out_data),
    .count   (fifo_count)
  );

  // Holdoff: start is ignored until pre-reset responses have flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              holdoff <= 2'(RESET_HOLDOFF);
    else if (holdoff != '0) holdoff <= holdoff - 2'd1;
  end

  // Reads in flight: issue adds one, an accepted response removes one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      unique case ({issue, push})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Transfer control FSM with registered busy/done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_en_q <= issue;
      unique case (state)
        IDLE: begin
          if (start && (holdoff == '0)) begin
            addr_q    <= base_addr & ~32'd1;
            remaining <= num_words;
            if (num_words == '0) begin
              done <= 1'b1;
            end else begin
              state <= ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q    <= addr_q + 32'(MEM_WORD_BYTES);
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a 3-cycle SPRAM model.
// Memory word at byte address a holds a[16:1] ^ 16'h5A5A.
module tb_mem_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic        busy, done;
  logic [31:0] mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_data_write;
  logic [15:0] mem_data_read;
  logic        mem_data_read_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  mem_stream_reader #(.FIFO_DEPTH(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .base_addr           (base_addr),
    .num_words           (num_words),
    .busy                (busy),
    .done                (done),
    .mem_addr            (mem_addr),
    .mem_rd_en           (mem_rd_en),
    .mem_wr_en           (mem_wr_en),
    .mem_data_write      (mem_data_write),
    .mem_data_read       (mem_data_read),
    .mem_data_read_valid (mem_data_read_valid),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[16:1] ^ 16'h5A5A;
  endfunction

  // Memory model: not reset, so in-flight reads survive a DUT reset.
  logic        v1 = 0, v2 = 0, v3 = 0;
  logic [15:0] d1 = 0, d2 = 0, d3 = 0;
  always @(posedge clk) begin
    v1 <= mem_rd_en; d1 <= mem_word(mem_addr);
    v2 <= v1;        d2 <= d1;
    v3 <= v2;        d3 <= d2;
  end
  assign mem_data_read       = d3;
  assign mem_data_read_valid = v3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [15:0] out_q[$];
  int          done_cnt = 0, done_cyc = -1, first_ov = -1;
  bit          busy_seen = 0;
  int          pulse_err = 0, wr_err = 0, stab_err = 0;
  logic        prev_rd = 0, prev_stall = 0;
  logic [15:0] prev_data = 0;

  always @(negedge clk) begin
    if (mem_rd_en === 1'b1) begin
      rd_addr_q.push_back(mem_addr);
      rd_cyc_q.push_back(cyc);
      if (prev_rd) pulse_err++;
    end
    prev_rd = (mem_rd_en === 1'b1);
    if (mem_wr_en !== 1'b0 || mem_data_write !== 16'h0) wr_err++;
    if (prev_stall && out_data !== prev_data) stab_err++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) out_q.push_back(out_data);
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_seen = 1;
  end

  int checks = 0, errors = 0, t0 = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    out_q.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    first_ov  = -1;
    busy_seen = 0;
  endtask

  task automatic go(input logic [31:0] b, input logic [15:0] n);
    base_addr = b;
    num_words = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && done_cnt == 0; i++) tick();
    check("done_seen", 32'(done_cnt != 0), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_wr_en", 32'(mem_wr_en), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_data", 32'(out_data), 0);
    reset = 1'b0;
    repeat (4) tick();

    // Basic 4-word read, consumer always ready
    clear_log();
    go(32'h0100, 16'd4);
    wait_done(60);
    repeat (2) tick();
    check("t1_nrd", rd_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", rd_addr_q[i], 32'h100 + 32'(2 * i));
      check("t1_rdcyc", rd_cyc_q[i], t0 + 2 * i);
    end
    check("t1_first_valid", first_ov, t0 + 4);
    check("t1_nout", out_q.size(), 4);
    check("t1_d0", 32'(out_q[0]), 32'h5ADA);
    check("t1_d1", 32'(out_q[1]), 32'h5ADB);
    check("t1_d2", 32'(out_q[2]), 32'h5AD8);
    check("t1_d3", 32'(out_q[3]), 32'h5AD9);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_cyc", done_cyc, t0 + 11);
    check("t1_busy", 32'(busy), 0);

    // Back-pressure: credit limit stalls after 4 reads
    clear_log();
    out_ready = 1'b0;
    go(32'h0201, 16'd10);
    repeat (20) tick();
    check("t2_stall_nrd", rd_addr_q.size(), 4);
    check("t2_stall_a0", rd_addr_q[0], 32'h200);
    check("t2_stall_a3", rd_addr_q[3], 32'h206);
    check("t2_stall_valid", 32'(out_valid), 1);
    check("t2_stall_head", 32'(out_data), 32'h5B5A);
    check("t2_stall_busy", 32'(busy), 1);
    out_ready = 1'b1;
    wait_done(200);
    tick();
    check("t2_nrd", rd_addr_q.size(), 10);
    check("t2_a9", rd_addr_q[9], 32'h212);
    check("t2_nout", out_q.size(), 10);
    for (int i = 0; i < 10; i++)
      check("t2_data", 32'(out_q[i]),
            32'(16'h5A5A ^ (16'h0100 + 16'(i))));
    check("t2_stable", stab_err, 0);

    // Address wrap across the 128 KB boundary
    clear_log();
    go(32'h0001_FFFC, 16'd3);
    wait_done(60);
    tick();
    check("t3_a0", rd_addr_q[0], 32'h0001_FFFC);
    check("t3_a1", rd_addr_q[1], 32'h0001_FFFE);
    check("t3_a2", rd_addr_q[2], 32'h0002_0000);
    check("t3_d0", 32'(out_q[0]), 32'hA5A4);
    check("t3_d1", 32'(out_q[1]), 32'hA5A5);
    check("t3_d2", 32'(out_q[2]), 32'h5A5A);
    check("t3_nout", out_q.size(), 3);

    // Empty transfer
    clear_log();
    go(32'h0010, 16'd0);
    check("t4_done_c1", 32'(done), 1);
    check("t4_busy_c1", 32'(busy), 0);
    tick();
    check("t4_done_c2", 32'(done), 0);
    repeat (4) tick();
    check("t4_nrd", rd_addr_q.size(), 0);
    check("t4_busy_seen", 32'(busy_seen), 0);
    check("t4_done_cnt", done_cnt, 1);

    // Start while busy is ignored
    clear_log();
    go(32'h0500, 16'd3);
    base_addr = 32'h0700;
    num_words = 16'd5;
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    wait_done(60);
    repeat (3) tick();
    check("t6_nrd", rd_addr_q.size(), 3);
    check("t6_a0", rd_addr_q[0], 32'h500);
    check("t6_a2", rd_addr_q[2], 32'h504);
    check("t6_nout", out_q.size(), 3);
    check("t6_d0", 32'(out_q[0]), 32'h58DA);
    check("t6_d1", 32'(out_q[1]), 32'h58DB);
    check("t6_d2", 32'(out_q[2]), 32'h58D8);
    check("t6_done_cnt", done_cnt, 1);

    // Reset mid-transfer, stale response, holdoff
    clear_log();
    go(32'h0300, 16'd4);
    check("t5_rd_before", 32'(mem_rd_en), 1);
    tick();
    reset = 1'b1;
    #1;
    check("t5_abort_busy", 32'(busy), 0);
    check("t5_abort_rd", 32'(mem_rd_en), 0);
    tick();
    clear_log();
    reset = 1'b0;
    base_addr = 32'h0400;
    num_words = 16'd2;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_holdoff_busy", 32'(busy), 0);
      check("t5_holdoff_valid", 32'(out_valid), 0);
    end
    tick();
    check("t5_accept", 32'(busy), 1);
    start = 1'b0;
    wait_done(60);
    tick();
    check("t5_nrd", rd_addr_q.size(), 2);
    check("t5_a0", rd_addr_q[0], 32'h400);
    check("t5_a1", rd_addr_q[1], 32'h402);
    check("t5_nout", out_q.size(), 2);
    check("t5_d0", 32'(out_q[0]), 32'h585A);
    check("t5_d1", 32'(out_q[1]), 32'h585B);

    // Protocol invariants over the whole run
    check("rd_en_single_pulse", pulse_err, 0);
    check("write_port_idle", wr_err, 0);
    check("stall_stability", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
